// File: rtl/comp_nbit_ncc_if.sv
// Chunk-stream interface for comp_nbit_ncc.
//   master drives: in_valid, g_input, e_input, abort, is_signed, op
//   slave drives : o, out_valid, busy
// W is the chunk width and must match the comparator's W.
interface comp_nbit_ncc_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic [W-1:0] g_input;
    logic [W-1:0] e_input;
    logic         abort;
    logic         is_signed;
    logic [1:0]   op;
    logic         o;
    logic         out_valid;
    logic         busy;

    modport master (
        output in_valid, g_input, e_input, abort, is_signed, op,
        input  o, out_valid, busy
    );

    modport slave (
        input  in_valid, g_input, e_input, abort, is_signed, op,
        output o, out_valid, busy
    );
endinterface

// File: rtl/comp_nbit_ncc.sv
// Multi-cycle N-bit comparator: two operands (garbler g, evaluator e) arrive
// as W-bit chunk pairs, LSB chunk first, one chunk per in_valid cycle.
// Only a two-bit running state (lt/eq) is kept between chunks.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus (slave)  in_valid/g_input/e_input/abort/is_signed/op in,
//                o/out_valid/busy out
// o = (g op e) for the last completed frame, out_valid pulses one cycle
// after the MSB chunk, busy is high while a frame is partially received.
module comp_nbit_ncc #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst,
    comp_nbit_ncc_if.slave    bus
);
    localparam int unsigned K  = N / W;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {
        OP_GE = 2'b00,
        OP_GT = 2'b01,
        OP_LT = 2'b10,
        OP_EQ = 2'b11
    } op_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lt_q, lt_d;
    logic          eq_q, eq_d;
    logic          o_q, o_d;
    logic          out_valid_q, out_valid_d;

    logic          is_last;
    logic [W-1:0]  g_cmp;
    logic [W-1:0]  e_cmp;
    logic          chunk_lt;
    logic          chunk_eq;
    logic          lt_next;
    logic          eq_next;
    op_e           op_sel;

    assign op_sel = op_e'(bus.op);

    always_comb begin
        is_last  = (cnt_q == LAST);
        g_cmp    = bus.g_input;
        e_cmp    = bus.e_input;
        // Flipping the sign bits of the MSB chunk turns the two's-complement
        // ordering into an unsigned one, so the same '<' serves both modes.
        if (is_last && bus.is_signed) begin
            g_cmp[W-1] = ~g_cmp[W-1];
            e_cmp[W-1] = ~e_cmp[W-1];
        end
        chunk_lt = (g_cmp < e_cmp);
        chunk_eq = (bus.g_input == bus.e_input);
        // A higher chunk decides unless it is equal, then lower chunks decide.
        lt_next  = chunk_lt | (chunk_eq & lt_q);
        eq_next  = chunk_eq & eq_q;

        cnt_d       = cnt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        o_d         = o_q;
        out_valid_d = 1'b0;

        if (bus.abort) begin
            cnt_d = '0;
            lt_d  = 1'b0;
            eq_d  = 1'b1;
        end else if (bus.in_valid) begin
            if (is_last) begin
                cnt_d       = '0;
                lt_d        = 1'b0;
                eq_d        = 1'b1;
                out_valid_d = 1'b1;
                unique case (op_sel)
                    OP_GE:   o_d = ~lt_next;
                    OP_GT:   o_d = ~lt_next & ~eq_next;
                    OP_LT:   o_d = lt_next;
                    OP_EQ:   o_d = eq_next;
                    default: o_d = 1'b0;
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
                lt_d  = lt_next;
                eq_d  = eq_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b1;
            o_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.o         = o_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_comp_nbit_ncc.sv
// Bench for comp_nbit_ncc: a 32/8 instance (four chunks per frame) and an
// 8/8 instance (one chunk per frame), checked against a full-width
// arithmetic reference and a cycle-exact out_valid scoreboard.
module tb_comp_nbit_ncc;
    logic clk;
    logic rst;

    comp_nbit_ncc_if #(.W(8)) bus32 ();
    comp_nbit_ncc_if #(.W(8)) bus8 ();

    comp_nbit_ncc #(.N(32), .W(8)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    comp_nbit_ncc #(.N(8),  .W(8)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic        o;
        int unsigned cyc;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    int unsigned cyc;
    int unsigned checks;
    int unsigned failures;
    bit          mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference relation on whole operands.
    function automatic logic ref32(input logic [31:0] g, input logic [31:0] e,
                                   input logic s, input logic [1:0] op);
        logic lt, eq;
        lt = s ? ($signed(g) < $signed(e)) : (g < e);
        eq = (g == e);
        case (op)
            2'b00:   return !lt;
            2'b01:   return !lt && !eq;
            2'b10:   return lt;
            default: return eq;
        endcase
    endfunction

    function automatic logic ref8(input logic [7:0] g, input logic [7:0] e,
                                  input logic s, input logic [1:0] op);
        logic lt, eq;
        lt = s ? ($signed(g) < $signed(e)) : (g < e);
        eq = (g == e);
        case (op)
            2'b00:   return !lt;
            2'b01:   return !lt && !eq;
            2'b10:   return lt;
            default: return eq;
        endcase
    endfunction

    // Per-cycle monitors: out_valid must be high exactly on the scheduled
    // cycle, and then o must match the reference.
    always @(negedge clk) begin
        if (mon_en) begin
            automatic bit due = (q32.size() > 0) && (q32[0].cyc == cyc);
            check("ov32", bus32.out_valid, due);
            if (due) begin
                check("o32", bus32.o, q32[0].o);
                void'(q32.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            automatic bit due = (q8.size() > 0) && (q8[0].cyc == cyc);
            check("ov8", bus8.out_valid, due);
            if (due) begin
                check("o8", bus8.o, q8[0].o);
                void'(q8.pop_front());
            end
        end
    end

    task automatic drive32(input logic [7:0] g, input logic [7:0] e, input logic s,
                           input logic [1:0] op, input logic v, input logic ab);
        bus32.in_valid  = v;
        bus32.g_input   = g;
        bus32.e_input   = e;
        bus32.is_signed = s;
        bus32.op        = op;
        bus32.abort     = ab;
        @(negedge clk);
    endtask

    task automatic idle32();
        drive32(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), 1'b0, 1'b0);
    endtask

    // Full frame; gap_len idle cycles inserted before chunk gap_at (4 = none).
    task automatic send_frame(input logic [31:0] g, input logic [31:0] e, input logic s,
                              input logic [1:0] op, input int gap_at, input int gap_len);
        for (int i = 0; i < 4; i++) begin
            if (i == gap_at) begin
                for (int j = 0; j < gap_len; j++) begin
                    idle32();
                    check("busy_gap", bus32.busy, (i != 0));
                end
            end
            if (i == 3) begin
                q32.push_back('{o: ref32(g, e, s, op), cyc: cyc + 1});
                drive32(g[31:24], e[31:24], s, op, 1'b1, 1'b0);
            end else begin
                drive32(8'(g >> (8 * i)), 8'(e >> (8 * i)), 1'($urandom), 2'($urandom),
                        1'b1, 1'b0);
            end
        end
    endtask

    // Partial frame of n chunks, the last of which carries abort (n==4 kills
    // the MSB cycle itself).
    task automatic aborted_frame(input int n);
        for (int i = 0; i < n; i++)
            drive32(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), 1'b1,
                    (i == n - 1));
    endtask

    task automatic send8(input logic [7:0] g, input logic [7:0] e, input logic s,
                         input logic [1:0] op);
        q8.push_back('{o: ref8(g, e, s, op), cyc: cyc + 1});
        bus8.in_valid  = 1'b1;
        bus8.g_input   = g;
        bus8.e_input   = e;
        bus8.is_signed = s;
        bus8.op        = op;
        bus8.abort     = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle8();
        bus8.in_valid = 1'b0;
        bus8.abort    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] g, e;
        logic [31:0] ext[4];
        ext[0] = 32'h0000_0000;
        ext[1] = 32'hFFFF_FFFF;
        ext[2] = 32'h8000_0000;
        ext[3] = 32'h7FFF_FFFF;
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        bus32.in_valid = 1'b0; bus32.abort = 1'b0; bus32.g_input = '0;
        bus32.e_input  = '0;   bus32.is_signed = 1'b0; bus32.op = 2'b00;
        bus8.in_valid  = 1'b0; bus8.abort = 1'b0; bus8.g_input = '0;
        bus8.e_input   = '0;   bus8.is_signed = 1'b0; bus8.op = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_o32", bus32.o, 0);
        check("rst_ov32", bus32.out_valid, 0);
        check("rst_busy32", bus32.busy, 0);
        check("rst_o8", bus8.o, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed frames.
        send_frame(32'h0000_00A9, 32'h0000_007B, 1'b0, 2'b00, 4, 0);
        idle32();
        send_frame(32'h0000_0074, 32'h0000_00FD, 1'b0, 2'b00, 4, 0);
        for (int op = 0; op < 4; op++)
            send_frame(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 2'(op), 4, 0);
        send_frame(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 2'b10, 4, 0);
        send_frame(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2'b10, 4, 0);
        send_frame(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 2'b01, 4, 0);
        send_frame(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 2'b01, 4, 0);
        send_frame(32'h1234_5678, 32'h1234_5600, 1'b0, 2'b01, 2, 5);
        idle32();

        // Abort after two chunks, abort together with a valid chunk, abort on MSB.
        aborted_frame(2);
        aborted_frame(3);
        aborted_frame(4);
        check("busy_abort", bus32.busy, 0);
        send_frame(32'h0000_0010, 32'h0000_0020, 1'b0, 2'b10, 4, 0);
        idle32();

        // K==1 sequence back to back, out_valid held for three cycles.
        send8(8'hA9, 8'h7B, 1'b0, 2'b00);
        send8(8'h74, 8'hFD, 1'b0, 2'b00);
        send8(8'hAA, 8'hAA, 1'b0, 2'b00);
        idle8();

        // Reset mid-frame after three chunks; last results were o=1.
        send_frame(32'h0000_0005, 32'h0000_0005, 1'b0, 2'b11, 4, 0);
        for (int i = 0; i < 3; i++)
            drive32(8'($urandom), 8'($urandom), 1'b0, 2'b00, 1'b1, 1'b0);
        rst = 1'b1;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_o32", bus32.o, 0);
        check("rst_mid_busy32", bus32.busy, 0);
        check("rst_mid_o8", bus8.o, 0);
        idle32();

        // Randomized frames, including back-to-back runs, gaps and aborts.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: begin g = $urandom; e = $urandom; end
                1: begin g = $urandom; e = g; end
                2: begin g = $urandom; e = {g[31:8], 8'($urandom)}; end
                default: begin g = ext[$urandom_range(0, 3)]; e = ext[$urandom_range(0, 3)]; end
            endcase
            if ($urandom_range(0, 7) == 0)
                aborted_frame($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0)
                send_frame(g, e, 1'($urandom), 2'($urandom), $urandom_range(0, 3),
                           $urandom_range(1, 4));
            else
                send_frame(g, e, 1'($urandom), 2'($urandom), 4, 0);
            if ($urandom_range(0, 2) == 0)
                idle32();
        end
        idle32();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                send8(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
            end else begin
                g = $urandom;
                send8(g[7:0], ($urandom_range(0, 2) == 0) ? g[7:0] : 8'($urandom),
                      1'($urandom), 2'($urandom));
            end
            if ($urandom_range(0, 3) == 0)
                idle8();
        end
        idle8();

        repeat (3) @(negedge clk);
        check("q32_drained", q32.size(), 0);
        check("q8_drained", q8.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
